// File: rtl/vga_pkg.sv
// Shared VGA timing constants and colour names for the 160x120 framebuffer
// and the drawing FSMs that fill it.
package vga_pkg;
    localparam int H_ACTIVE    = 640;
    localparam int H_FP        = 16;
    localparam int H_SYNC      = 96;
    localparam int H_BP        = 48;
    localparam int H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_ACTIVE    = 480;
    localparam int V_FP        = 10;
    localparam int V_SYNC      = 2;
    localparam int V_BP        = 33;
    localparam int V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XRES        = 160;
    localparam int YRES        = 120;
    localparam int SCALE_SHIFT = 2;
    localparam int COLOR_W     = 3;
    localparam int ADDR_W      = 15;
    localparam int CNT_W       = 10;

    typedef enum logic [COLOR_W-1:0] {
        BLACK   = 3'b000,
        BLUE    = 3'b001,
        GREEN   = 3'b010,
        CYAN    = 3'b011,
        RED     = 3'b100,
        MAGENTA = 3'b101,
        YELLOW  = 3'b110,
        WHITE   = 3'b111
    } colour_e;
endpackage

// File: rtl/vga_fb_scanout_if.sv
// Framebuffer read port plus VGA DAC/sync pins; the scanout is the master.
interface vga_fb_scanout_if;
    import vga_pkg::*;

    logic [ADDR_W-1:0]  rd_addr;
    logic [COLOR_W-1:0] rd_data;
    logic [7:0]         VGA_R;
    logic [7:0]         VGA_G;
    logic [7:0]         VGA_B;
    logic               VGA_HS;
    logic               VGA_VS;
    logic               VGA_BLANK_N;
    logic               VGA_SYNC_N;
    logic               VGA_CLK;
    logic               frame_tick;
    logic               in_vblank;

    modport master (
        output rd_addr, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
               VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, frame_tick, in_vblank,
        input  rd_data
    );

    modport slave (
        input  rd_addr, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
               VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, frame_tick, in_vblank,
        output rd_data
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Pixel enable, h/v raster counters, raw sync/active flags and the
// once-per-frame tick at the start of vertical blanking.
module vga_timing_gen
    import vga_pkg::CNT_W;
#(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic             o_pix_en,
    output logic [CNT_W-1:0] o_hcount,
    output logic [CNT_W-1:0] o_vcount,
    output logic             o_hs_raw,
    output logic             o_vs_raw,
    output logic             o_active_raw,
    output logic             o_frame_tick,
    output logic             o_in_vblank
);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic             r_pix_en;
    logic [CNT_W-1:0] r_hcount;
    logic [CNT_W-1:0] r_vcount;
    logic             r_frame_tick;
    logic             r_in_vblank;
    logic [CNT_W-1:0] w_hnext;
    logic [CNT_W-1:0] w_vnext;

    always_comb begin
        w_hnext = r_hcount + CNT_W'(1);
        w_vnext = r_vcount;
        if (r_hcount == H_LAST) begin
            w_hnext = '0;
            w_vnext = (r_vcount == V_LAST) ? '0 : r_vcount + CNT_W'(1);
        end
    end

    // The tick is decoded from the next counter value so it lands on the
    // same edge that moves the raster into line V_ACTIVE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pix_en     <= 1'b0;
            r_hcount     <= '0;
            r_vcount     <= '0;
            r_frame_tick <= 1'b0;
            r_in_vblank  <= 1'b0;
        end else begin
            r_pix_en     <= ~r_pix_en;
            r_frame_tick <= 1'b0;
            if (r_pix_en) begin
                r_hcount     <= w_hnext;
                r_vcount     <= w_vnext;
                r_in_vblank  <= (w_vnext >= V_ACT_C);
                r_frame_tick <= (w_hnext == '0) && (w_vnext == V_ACT_C);
            end
        end
    end

    assign o_pix_en     = r_pix_en;
    assign o_hcount     = r_hcount;
    assign o_vcount     = r_vcount;
    assign o_hs_raw     = !((r_hcount >= HS_START) && (r_hcount < HS_END));
    assign o_vs_raw     = !((r_vcount >= VS_START) && (r_vcount < VS_END));
    assign o_active_raw = (r_hcount < H_ACT_C) && (r_vcount < V_ACT_C);
    assign o_frame_tick = r_frame_tick;
    assign o_in_vblank  = r_in_vblank;
endmodule

// File: rtl/vga_fb_scanout.sv
// Framebuffer scanout: 4x4-scaled 160x120 image to 640x480@60 VGA pins
// through a two-pixel pipeline (address issue, then colour capture).
module vga_fb_scanout
    import vga_pkg::CNT_W, vga_pkg::ADDR_W, vga_pkg::SCALE_SHIFT;
#(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic            i_clk,
    input  logic            i_rst,
    vga_fb_scanout_if.master vga
);
    function automatic logic [7:0] dac_level(input logic bit_in);
        return {8{bit_in}};
    endfunction

    // y*160 + x, built from shifts since 160 = 128 + 32.
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [CNT_W-1:0] h,
                                                  input logic [CNT_W-1:0] v);
        logic [ADDR_W-1:0] row;
        row = ADDR_W'(v >> SCALE_SHIFT);
        return (row << 7) + (row << 5) + ADDR_W'(h >> SCALE_SHIFT);
    endfunction

    logic             w_pix_en;
    logic [CNT_W-1:0] w_hcount;
    logic [CNT_W-1:0] w_vcount;
    logic             w_hs_raw;
    logic             w_vs_raw;
    logic             w_active_raw;

    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_hs_p0;
    logic              r_vs_p0;
    logic              r_act_p0;
    logic [7:0]        r_red_p1;
    logic [7:0]        r_grn_p1;
    logic [7:0]        r_blu_p1;
    logic              r_hs_p1;
    logic              r_vs_p1;
    logic              r_blank_n_p1;
    logic              r_vga_clk;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .o_pix_en    (w_pix_en),
        .o_hcount    (w_hcount),
        .o_vcount    (w_vcount),
        .o_hs_raw    (w_hs_raw),
        .o_vs_raw    (w_vs_raw),
        .o_active_raw(w_active_raw),
        .o_frame_tick(vga.frame_tick),
        .o_in_vblank (vga.in_vblank)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_addr    <= '0;
            r_hs_p0      <= 1'b1;
            r_vs_p0      <= 1'b1;
            r_act_p0     <= 1'b0;
            r_red_p1     <= 8'h00;
            r_grn_p1     <= 8'h00;
            r_blu_p1     <= 8'h00;
            r_hs_p1      <= 1'b1;
            r_vs_p1      <= 1'b1;
            r_blank_n_p1 <= 1'b0;
            r_vga_clk    <= 1'b0;
        end else begin
            r_vga_clk <= w_pix_en;
            if (w_pix_en) begin
                // Stage 0: issue read address, capture this pixel's flags
                if (w_active_raw) begin
                    r_rd_addr <= fb_addr(w_hcount, w_vcount);
                end
                r_hs_p0  <= w_hs_raw;
                r_vs_p0  <= w_vs_raw;
                r_act_p0 <= w_active_raw;
                // Stage 1: colour from RAM meets its own delayed flags
                r_red_p1     <= r_act_p0 ? dac_level(vga.rd_data[2]) : 8'h00;
                r_grn_p1     <= r_act_p0 ? dac_level(vga.rd_data[1]) : 8'h00;
                r_blu_p1     <= r_act_p0 ? dac_level(vga.rd_data[0]) : 8'h00;
                r_hs_p1      <= r_hs_p0;
                r_vs_p1      <= r_vs_p0;
                r_blank_n_p1 <= r_act_p0;
            end
        end
    end

    assign vga.rd_addr     = r_rd_addr;
    assign vga.VGA_R       = r_red_p1;
    assign vga.VGA_G       = r_grn_p1;
    assign vga.VGA_B       = r_blu_p1;
    assign vga.VGA_HS      = r_hs_p1;
    assign vga.VGA_VS      = r_vs_p1;
    assign vga.VGA_BLANK_N = r_blank_n_p1;
    assign vga.VGA_SYNC_N  = 1'b0;
    assign vga.VGA_CLK     = r_vga_clk;
endmodule

// File: tb/tb_vga_fb_scanout.sv
// Randomised-framebuffer bench for vga_fb_scanout: pins and read address are
// predicted each Clock from the elapsed Clock count since reset release.
module tb_vga_fb_scanout;
    import vga_pkg::*;

    // Short vertical raster so whole frames fit in a short run.
    localparam int TV_ACTIVE = 12;
    localparam int TV_FP     = 2;
    localparam int TV_SYNC   = 2;
    localparam int TV_BP     = 3;
    localparam int HT        = H_TOTAL;
    localparam int VT        = TV_ACTIVE + TV_FP + TV_SYNC + TV_BP;
    localparam int LINE_CLK  = 2 * HT;
    localparam int FRAME_CLK = LINE_CLK * VT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [COLOR_W-1:0] mem [XRES*YRES];

    vga_fb_scanout_if bus();

    vga_fb_scanout #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(TV_ACTIVE), .V_FP(TV_FP), .V_SYNC(TV_SYNC), .V_BP(TV_BP)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .vga  (bus)
    );

    always #10 clk = ~clk;

    always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

    int checks = 0;
    int errors = 0;
    int c;
    int exp_addr;
    logic [23:0] pix0_rgb;
    logic prev_hs, prev_vs, prev_vbl;
    int last_hs_fall, last_vs_fall, last_tick, last_vbl_rise;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (clock %0d)", tag, obs, exp, c);
        end
    endtask

    function automatic logic [23:0] rgb_of(input logic [2:0] col);
        return {col[2] ? 8'hFF : 8'h00, col[1] ? 8'hFF : 8'h00, col[0] ? 8'hFF : 8'h00};
    endfunction

    // {R,G,B,HS,VS,BLANK_N,SYNC_N,VGA_CLK,frame_tick,in_vblank} after Clock n
    function automatic logic [30:0] expect_pins(input int n);
        int m, k, hd, vd, v;
        logic hs, vs, act, tick, vbl, vclk;
        logic [23:0] rgb;
        m    = n / 2;
        v    = (m / HT) % VT;
        vclk = (n >= 2) && (n % 2 == 0);
        vbl  = (v >= TV_ACTIVE);
        tick = (n % 2 == 0) && (m > 0) && (m % (HT * VT) == HT * TV_ACTIVE);
        hs = 1'b1; vs = 1'b1; act = 1'b0; rgb = 24'h0;
        if (n >= 4) begin
            k   = m - 2;
            hd  = k % HT;
            vd  = (k / HT) % VT;
            hs  = !(hd >= H_ACTIVE + H_FP && hd < H_ACTIVE + H_FP + H_SYNC);
            vs  = !(vd >= TV_ACTIVE + TV_FP && vd < TV_ACTIVE + TV_FP + TV_SYNC);
            act = (hd < H_ACTIVE) && (vd < TV_ACTIVE);
            if (act) rgb = rgb_of(mem[(vd / 4) * XRES + hd / 4]);
        end
        return {rgb, hs, vs, act, 1'b0, vclk, tick, vbl};
    endfunction

    function automatic logic [30:0] pins_now();
        return {bus.VGA_R, bus.VGA_G, bus.VGA_B, bus.VGA_HS, bus.VGA_VS, bus.VGA_BLANK_N,
                bus.VGA_SYNC_N, bus.VGA_CLK, bus.frame_tick, bus.in_vblank};
    endfunction

    task automatic fill_mem(input logic [2:0] col0);
        for (int i = 0; i < XRES * YRES; i++) mem[i] = 3'($urandom);
        mem[0]   = col0;
        pix0_rgb = rgb_of(col0);
    endtask

    task automatic start_phase();
        c = 0; exp_addr = 0;
        prev_hs = 1'b1; prev_vs = 1'b1; prev_vbl = 1'b0;
        last_hs_fall = -1; last_vs_fall = -1; last_tick = -1; last_vbl_rise = -1;
    endtask

    task automatic reset_cycle(input string tag);
        rst = 1'b1;
        @(posedge clk); #1;
        check(tag, {1'b0, pins_now()}, {1'b0, expect_pins(0)});
        check({tag, "_addr"}, 32'(bus.rd_addr), 32'd0);
    endtask

    task automatic sample();
        int j, hj, vj, k;
        logic [30:0] p;
        p = pins_now();
        check("pins", {1'b0, p}, {1'b0, expect_pins(c)});
        if (c >= 2) begin
            j  = c / 2 - 1;
            hj = j % HT;
            vj = (j / HT) % VT;
            if (hj < H_ACTIVE && vj < TV_ACTIVE) exp_addr = (vj / 4) * XRES + hj / 4;
            if (c % 2 == 0 && vj == 0 && hj == 4) check("addr_4_0", 32'(bus.rd_addr), 32'd1);
            if (c % 2 == 0 && vj == 4 && hj == 0) check("addr_0_4", 32'(bus.rd_addr), 32'd160);
            if (c % 2 == 0 && vj == 3 && hj == 3) check("addr_3_3", 32'(bus.rd_addr), 32'd0);
            if (c % 2 == 0 && vj == TV_ACTIVE - 1 && hj == H_ACTIVE - 1)
                check("addr_last", 32'(bus.rd_addr), 32'((TV_ACTIVE / 4 - 1) * XRES + XRES - 1));
        end
        check("rd_addr", 32'(bus.rd_addr), 32'(exp_addr));
        if (c >= 4 && c % 2 == 0) begin
            k = c / 2 - 2;
            if (k % HT < 4 && (k / HT) % VT < 4)
                check("pix0_rgb", {8'h0, bus.VGA_R, bus.VGA_G, bus.VGA_B}, {8'h0, pix0_rgb});
        end
        if (prev_hs && !bus.VGA_HS) begin
            if (last_hs_fall < 0) check("hs_first_fall", 32'(c), 32'(2 * (H_ACTIVE + H_FP) + 4));
            else                  check("hs_period", 32'(c - last_hs_fall), 32'(LINE_CLK));
            last_hs_fall = c;
        end
        if (!prev_hs && bus.VGA_HS && last_hs_fall >= 0)
            check("hs_low_width", 32'(c - last_hs_fall), 32'(2 * H_SYNC));
        if (prev_vs && !bus.VGA_VS) last_vs_fall = c;
        if (!prev_vs && bus.VGA_VS && last_vs_fall >= 0)
            check("vs_low_width", 32'(c - last_vs_fall), 32'(TV_SYNC * LINE_CLK));
        if (bus.frame_tick) begin
            if (last_tick < 0) check("tick_first", 32'(c), 32'(TV_ACTIVE * LINE_CLK));
            else               check("tick_interval", 32'(c - last_tick), 32'(FRAME_CLK));
            last_tick = c;
        end
        if (!prev_vbl && bus.in_vblank) last_vbl_rise = c;
        if (prev_vbl && !bus.in_vblank && last_vbl_rise >= 0)
            check("vblank_width", 32'(c - last_vbl_rise), 32'((VT - TV_ACTIVE) * LINE_CLK));
        prev_hs  = bus.VGA_HS;
        prev_vs  = bus.VGA_VS;
        prev_vbl = bus.in_vblank;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            c++;
            sample();
        end
    endtask

    initial begin
        start_phase();
        fill_mem(RED);
        for (int i = 0; i < 5; i++) reset_cycle("reset");
        rst = 1'b0;
        start_phase();
        // Stop with the counters at (300, 8), mid-way through the first frame.
        run_cycles(2 * (8 * HT + 300));
        reset_cycle("mid_reset");
        fill_mem(CYAN);
        reset_cycle("mid_reset_hold");
        rst = 1'b0;
        start_phase();
        run_cycles(2 * FRAME_CLK + 400);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
